// File: rtl/fill_sequencer_if.sv
// Bundle of the fill_sequencer control inputs and status/actuator outputs.
// The sequencer uses the slave modport; the button/display side uses master.
interface fill_sequencer_if;
  logic       tick_1s;
  logic       pill_in;
  logic       start;
  logic       clear;
  logic       estop;
  logic       conveyor_fault;
  logic [9:0] target_pills;
  logic [6:0] target_bottles;
  logic [2:0] state;
  logic [9:0] now_pills;
  logic [6:0] now_bottles;
  logic       valve_open;
  logic       conveyor_run;
  logic [1:0] alarm;

  modport master (
    output tick_1s, pill_in, start, clear, estop, conveyor_fault,
           target_pills, target_bottles,
    input  state, now_pills, now_bottles, valve_open, conveyor_run, alarm
  );

  modport slave (
    input  tick_1s, pill_in, start, clear, estop, conveyor_fault,
           target_pills, target_bottles,
    output state, now_pills, now_bottles, valve_open, conveyor_run, alarm
  );
endinterface

// File: rtl/fill_sequencer.sv
// Pill-bottling sequencer: batch state machine, pill/bottle counters, changeover
// and starvation timers. Optional pill input filter: FILL_PILL_DEBOUNCE_EN.
module fill_sequencer #(
  parameter int unsigned SWITCH_SECS = 3,
  parameter int unsigned HOPPER_SECS = 5
) (
  input logic            clk_1khz,
  input logic            rst_n,
  fill_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    ST_SETTING   = 3'd0,
    ST_RUNNING   = 3'd1,
    ST_SWITCHING = 3'd2,
    ST_DONE      = 3'd3,
    ST_ERROR     = 3'd4,
    ST_FATAL     = 3'd5
  } state_t;

  localparam logic [3:0] SWITCH_LOAD = 4'(SWITCH_SECS);
  localparam logic [3:0] HOPPER_LOAD = 4'(HOPPER_SECS);

  state_t     state_reg, state_next;
  logic [9:0] pills_reg, pills_next;
  logic [6:0] bottles_reg, bottles_next;
  logic [3:0] hopper_reg, hopper_next;
  logic [3:0] switch_reg, switch_next;
  logic [9:0] tgt_pills_reg, tgt_pills_next;
  logic [6:0] tgt_bottles_reg, tgt_bottles_next;
  logic       from_switch_reg, from_switch_next;
  logic       valve_reg, conveyor_reg;
  logic [1:0] alarm_reg;

  logic       start_prev_reg, clear_prev_reg, pill_prev_reg;
  logic [1:0] pill_sync_reg;
  logic       pill_level;
  logic       start_edge, clear_edge, pill_edge;
  logic [9:0] pills_inc;
  logic [6:0] bottles_inc;

  always_ff @(posedge clk_1khz) begin
    if (!rst_n) begin
      pill_sync_reg <= 2'b00;
    end else begin
      pill_sync_reg <= {pill_sync_reg[0], bus.pill_in};
    end
  end

`ifdef FILL_PILL_DEBOUNCE_EN
  // Accept a new level only after it has differed from the filtered level
  // for four consecutive samples.
  logic [1:0] db_cnt_reg;
  logic       db_level_reg;

  always_ff @(posedge clk_1khz) begin
    if (!rst_n) begin
      db_cnt_reg   <= 2'd0;
      db_level_reg <= 1'b0;
    end else if (pill_sync_reg[1] == db_level_reg) begin
      db_cnt_reg <= 2'd0;
    end else if (db_cnt_reg == 2'd3) begin
      db_cnt_reg   <= 2'd0;
      db_level_reg <= pill_sync_reg[1];
    end else begin
      db_cnt_reg <= db_cnt_reg + 2'd1;
    end
  end

  assign pill_level = db_level_reg;
`else
  assign pill_level = pill_sync_reg[1];
`endif

  assign start_edge  = bus.start & ~start_prev_reg;
  assign clear_edge  = bus.clear & ~clear_prev_reg;
  assign pill_edge   = pill_level & ~pill_prev_reg;
  assign pills_inc   = pills_reg + 10'd1;
  assign bottles_inc = bottles_reg + 7'd1;

  always_ff @(posedge clk_1khz) begin
    if (!rst_n) begin
      state_reg       <= ST_SETTING;
      pills_reg       <= 10'd0;
      bottles_reg     <= 7'd0;
      hopper_reg      <= 4'd0;
      switch_reg      <= 4'd0;
      tgt_pills_reg   <= 10'd0;
      tgt_bottles_reg <= 7'd0;
      from_switch_reg <= 1'b0;
      valve_reg       <= 1'b0;
      conveyor_reg    <= 1'b0;
      alarm_reg       <= 2'd0;
      start_prev_reg  <= 1'b0;
      clear_prev_reg  <= 1'b0;
      pill_prev_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pills_reg       <= pills_next;
      bottles_reg     <= bottles_next;
      hopper_reg      <= hopper_next;
      switch_reg      <= switch_next;
      tgt_pills_reg   <= tgt_pills_next;
      tgt_bottles_reg <= tgt_bottles_next;
      from_switch_reg <= from_switch_next;
      // Actuators follow the next state so they change together with state.
      valve_reg       <= (state_next == ST_RUNNING);
      conveyor_reg    <= (state_next == ST_SWITCHING);
      case (state_next)
        ST_DONE:  alarm_reg <= 2'd1;
        ST_ERROR: alarm_reg <= 2'd2;
        ST_FATAL: alarm_reg <= 2'd3;
        default:  alarm_reg <= 2'd0;
      endcase
      start_prev_reg  <= bus.start;
      clear_prev_reg  <= bus.clear;
      pill_prev_reg   <= pill_level;
    end
  end

  always_comb begin
    state_next       = state_reg;
    pills_next       = pills_reg;
    bottles_next     = bottles_reg;
    hopper_next      = hopper_reg;
    switch_next      = switch_reg;
    tgt_pills_next   = tgt_pills_reg;
    tgt_bottles_next = tgt_bottles_reg;
    from_switch_next = from_switch_reg;

    if (bus.estop) begin
      state_next = ST_FATAL;
    end else if (clear_edge) begin
      state_next   = ST_SETTING;
      pills_next   = 10'd0;
      bottles_next = 7'd0;
      hopper_next  = 4'd0;
      switch_next  = 4'd0;
    end else begin
      case (state_reg)
        ST_SETTING: begin
          if (start_edge && bus.target_pills != 10'd0 && bus.target_bottles != 7'd0) begin
            tgt_pills_next   = bus.target_pills;
            tgt_bottles_next = bus.target_bottles;
            hopper_next      = HOPPER_LOAD;
            state_next       = ST_RUNNING;
          end
        end
        ST_RUNNING: begin
          // A pill reload beats a same-cycle tick that would expire the timer.
          if (pill_edge) begin
            pills_next  = pills_inc;
            hopper_next = HOPPER_LOAD;
            if (pills_inc == tgt_pills_reg) begin
              bottles_next = bottles_inc;
              if (bottles_inc == tgt_bottles_reg) begin
                state_next = ST_DONE;
              end else begin
                switch_next = SWITCH_LOAD;
                state_next  = ST_SWITCHING;
              end
            end
          end else if (bus.tick_1s) begin
            hopper_next = hopper_reg - 4'd1;
            if (hopper_reg <= 4'd1) begin
              hopper_next      = 4'd0;
              from_switch_next = 1'b0;
              state_next       = ST_ERROR;
            end
          end
        end
        ST_SWITCHING: begin
          pills_next = 10'd0;
          if (bus.conveyor_fault) begin
            from_switch_next = 1'b1;
            state_next       = ST_ERROR;
          end else if (bus.tick_1s) begin
            switch_next = switch_reg - 4'd1;
            if (switch_reg <= 4'd1) begin
              switch_next = 4'd0;
              hopper_next = HOPPER_LOAD;
              state_next  = ST_RUNNING;
            end
          end
        end
        ST_ERROR: begin
          if (start_edge && !bus.conveyor_fault) begin
            if (from_switch_reg) begin
              switch_next = SWITCH_LOAD;
              state_next  = ST_SWITCHING;
            end else begin
              hopper_next = HOPPER_LOAD;
              state_next  = ST_RUNNING;
            end
          end
        end
        default: begin
          // DONE and FATAL wait for clear (FATAL also needs estop released).
        end
      endcase
    end
  end

  assign bus.state        = state_reg;
  assign bus.now_pills    = pills_reg;
  assign bus.now_bottles  = bottles_reg;
  assign bus.valve_open   = valve_reg;
  assign bus.conveyor_run = conveyor_reg;
  assign bus.alarm        = alarm_reg;

endmodule

// File: tb/tb_fill_sequencer.sv
// Self-checking bench for fill_sequencer: vector table plus hand sequences for
// latency, same-cycle pill/expiry, pill filter and mid-run reset.
`timescale 1ns/1ps
module tb_fill_sequencer;

`ifdef FILL_PILL_DEBOUNCE_EN
  localparam int LAT = 7;
  localparam int GLITCH_COUNT = 0;
`else
  localparam int LAT = 3;
  localparam int GLITCH_COUNT = 1;
`endif

  localparam int S_SET = 0, S_RUN = 1, S_SW = 2, S_DONE = 3, S_ERR = 4, S_FAT = 5;

  typedef struct {
    string name;
    bit    start, clear, estop, fault;
    int    pills, ticks, tp, tb;
    int    st, np, nb;
  } vec_t;

  typedef struct {
    string name;
    int    st, np, nb;
  } exp_t;

  logic clk;
  logic rst_n;
  fill_sequencer_if bus ();

  fill_sequencer dut (
    .clk_1khz (clk),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add(string n, bit s, bit c, bit e, bit f, int p, int t,
                     int tp, int tb, int st, int np, int nb);
    vec_t v;
    v.name = n; v.start = s; v.clear = c; v.estop = e; v.fault = f;
    v.pills = p; v.ticks = t; v.tp = tp; v.tb = tb;
    v.st = st; v.np = np; v.nb = nb;
    vecs.push_back(v);
  endtask

  task automatic expect_out(string n, int st, int np, int nb);
    exp_t e;
    e.name = n; e.st = st; e.np = np; e.nb = nb;
    exp_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    int   ev, ec, ea;
    n_total++;
    if (exp_q.size() == 0) begin
      $display("FAIL scoreboard: output with no expectation queued");
      return;
    end
    e  = exp_q.pop_front();
    ev = (e.st == S_RUN) ? 1 : 0;
    ec = (e.st == S_SW) ? 1 : 0;
    ea = (e.st == S_DONE) ? 1 : (e.st == S_ERR) ? 2 : (e.st == S_FAT) ? 3 : 0;
    if (int'(bus.state) != e.st || int'(bus.now_pills) != e.np ||
        int'(bus.now_bottles) != e.nb || int'(bus.valve_open) != ev ||
        int'(bus.conveyor_run) != ec || int'(bus.alarm) != ea) begin
      $display("FAIL %s: got state=%0d pills=%0d bottles=%0d valve=%0d conv=%0d alarm=%0d, expected state=%0d pills=%0d bottles=%0d valve=%0d conv=%0d alarm=%0d",
               e.name, bus.state, bus.now_pills, bus.now_bottles, bus.valve_open,
               bus.conveyor_run, bus.alarm, e.st, e.np, e.nb, ev, ec, ea);
    end else begin
      n_pass++;
      $display("ok   %s: state=%0d pills=%0d bottles=%0d alarm=%0d",
               e.name, bus.state, bus.now_pills, bus.now_bottles, bus.alarm);
    end
  endtask

  task automatic pill_pulse(int hi);
    bus.pill_in = 1'b1;
    repeat (hi) cyc();
    bus.pill_in = 1'b0;
    repeat (8) cyc();
  endtask

  task automatic tick_pulse();
    bus.tick_1s = 1'b1;
    cyc();
    bus.tick_1s = 1'b0;
    cyc();
  endtask

  task automatic press_start();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    cyc();
  endtask

  task automatic press_clear();
    bus.clear = 1'b1;
    cyc();
    bus.clear = 1'b0;
    cyc();
  endtask

  task automatic apply(vec_t v);
    bus.target_pills   = 10'(v.tp);
    bus.target_bottles = 7'(v.tb);
    bus.estop          = v.estop;
    bus.conveyor_fault = v.fault;
    expect_out(v.name, v.st, v.np, v.nb);
    if (v.clear) press_clear();
    if (v.start) press_start();
    repeat (v.pills) pill_pulse(6);
    repeat (v.ticks) tick_pulse();
    cyc();
    cyc();
    check_out();
  endtask

  initial begin
    //   name            st cl es fl pills ticks  tp   tb   state   np nb
    add("batch_start",    1, 0, 0, 0, 0, 0,   3,   2, S_RUN,  0, 0);
    add("bottle1_full",   0, 0, 0, 0, 3, 0,   3,   2, S_SW,   0, 1);
    add("switch_2ticks",  0, 0, 0, 0, 0, 2,   3,   2, S_SW,   0, 1);
    add("switch_expire",  0, 0, 0, 0, 0, 1,   3,   2, S_RUN,  0, 1);
    add("batch_done",     0, 0, 0, 0, 3, 0,   3,   2, S_DONE, 3, 2);
    add("done_ign_start", 1, 0, 0, 0, 0, 0,   3,   2, S_DONE, 3, 2);
    add("done_clear",     0, 1, 0, 0, 0, 0,   3,   2, S_SET,  0, 0);
    add("starve_start",   1, 0, 0, 0, 0, 0,   3,   2, S_RUN,  0, 0);
    add("starve_pill",    0, 0, 0, 0, 1, 0,   3,   2, S_RUN,  1, 0);
    add("starve_4ticks",  0, 0, 0, 0, 0, 4,   3,   2, S_RUN,  1, 0);
    add("starve_error",   0, 0, 0, 0, 0, 1,   3,   2, S_ERR,  1, 0);
    add("err_pill_drop",  0, 0, 0, 0, 1, 0,   3,   2, S_ERR,  1, 0);
    add("err_resume",     1, 0, 0, 0, 0, 0,   3,   2, S_RUN,  1, 0);
    add("resume_4ticks",  0, 0, 0, 0, 0, 4,   3,   2, S_RUN,  1, 0);
    add("resume_expire",  0, 0, 0, 0, 0, 1,   3,   2, S_ERR,  1, 0);
    add("fill_to_switch", 1, 0, 0, 0, 2, 0,   3,   2, S_SW,   0, 1);
    add("conv_fault",     0, 0, 0, 1, 0, 0,   3,   2, S_ERR,  0, 1);
    add("start_in_fault", 1, 0, 0, 1, 0, 0,   3,   2, S_ERR,  0, 1);
    add("resume_switch",  1, 0, 0, 0, 0, 0,   3,   2, S_SW,   0, 1);
    add("rsw_2ticks",     0, 0, 0, 0, 0, 2,   3,   2, S_SW,   0, 1);
    add("rsw_expire",     0, 0, 0, 0, 0, 1,   3,   2, S_RUN,  0, 1);
    add("clear_run",      0, 1, 0, 0, 0, 0,   3,   2, S_SET,  0, 0);
    add("es_start",       1, 0, 0, 0, 0, 0,   3,   2, S_RUN,  0, 0);
    add("es_to_switch",   0, 0, 0, 0, 3, 0,   3,   2, S_SW,   0, 1);
    add("estop_fatal",    0, 0, 1, 0, 0, 0,   3,   2, S_FAT,  0, 1);
    add("clear_in_estop", 0, 1, 1, 0, 0, 0,   3,   2, S_FAT,  0, 1);
    add("estop_release",  0, 0, 0, 0, 0, 0,   3,   2, S_FAT,  0, 1);
    add("fatal_clear",    0, 1, 0, 0, 0, 0,   3,   2, S_SET,  0, 0);
    add("zero_pills",     1, 0, 0, 0, 0, 0,   0,   2, S_SET,  0, 0);
    add("zero_bottles",   1, 0, 0, 0, 0, 0,   3,   0, S_SET,  0, 0);
    add("max_start",      1, 0, 0, 0, 0, 0, 999,  99, S_RUN,  0, 0);
    add("latched_tgt",    0, 0, 0, 0, 1, 0,   1,   1, S_RUN,  1, 0);
    add("final_clear",    0, 1, 0, 0, 0, 0,   1,   1, S_SET,  0, 0);

    rst_n = 1'b0;
    bus.tick_1s = 1'b0; bus.pill_in = 1'b0; bus.start = 1'b0; bus.clear = 1'b0;
    bus.estop = 1'b0; bus.conveyor_fault = 1'b0;
    bus.target_pills = 10'd10; bus.target_bottles = 7'd1;
    cyc();
    cyc();
    expect_out("reset", S_SET, 0, 0);
    check_out();
    rst_n = 1'b1;
    cyc();

    // Start edge acts on the first edge it is seen high.
    bus.start = 1'b1;
    expect_out("start_latency", S_RUN, 0, 0);
    cyc();
    check_out();
    bus.start = 1'b0;
    cyc();

    // Pill count appears exactly LAT edges after the input rises.
    bus.pill_in = 1'b1;
    expect_out("pill_lat_before", S_RUN, 0, 0);
    repeat (LAT - 1) cyc();
    check_out();
    expect_out("pill_lat_at", S_RUN, 1, 0);
    cyc();
    check_out();
    bus.pill_in = 1'b0;
    repeat (10) cyc();

    // Pill edge coincident with the expiring tick.
    repeat (4) tick_pulse();
    bus.pill_in = 1'b1;
    repeat (LAT - 1) cyc();
    bus.tick_1s = 1'b1;
    expect_out("pill_vs_expiry", S_RUN, 2, 0);
    cyc();
    bus.tick_1s = 1'b0;
    check_out();
    bus.pill_in = 1'b0;
    repeat (10) cyc();
    repeat (4) tick_pulse();
    expect_out("reload_4ticks", S_RUN, 2, 0);
    check_out();
    expect_out("reload_expire", S_ERR, 2, 0);
    tick_pulse();
    check_out();

    // Pill filter: short glitch then a long pulse.
    press_clear();
    press_start();
    bus.pill_in = 1'b1;
    cyc();
    cyc();
    bus.pill_in = 1'b0;
    repeat (12) cyc();
    expect_out("glitch", S_RUN, GLITCH_COUNT, 0);
    check_out();
    bus.pill_in = 1'b1;
    repeat (10) cyc();
    bus.pill_in = 1'b0;
    repeat (12) cyc();
    expect_out("long_pulse", S_RUN, GLITCH_COUNT + 1, 0);
    check_out();

    // Reset mid-run.
    rst_n = 1'b0;
    expect_out("mid_reset", S_SET, 0, 0);
    cyc();
    rst_n = 1'b1;
    check_out();
    cyc();

    foreach (vecs[i]) apply(vecs[i]);

    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fill_sequencer.md
# fill_sequencer

Sequencer for the pill-bottling line. It replaces the debug-switch state selection with a real SETTING/RUNNING/SWITCHING/DONE/ERROR/FATAL state machine. It counts pills per bottle and completed bottles, times the bottle changeover and hopper starvation, and drives the valve, conveyor and alarm mode. It sits between the button/switch inputs and the display/beeper logic, and its `state` output uses the same 3-bit code the display animation decodes.

## Interface
- `SWITCH_SECS`, default 3: seconds the conveyor runs to place the next bottle (1..15).
- `HOPPER_SECS`, default 5: seconds without a pill in RUNNING before ERROR (1..15).
- `clk_1khz` input, 1 bit: single clock, 1 kHz. All logic is on its rising edge.
- `rst_n` input, 1 bit: reset, synchronous and active-low.
- `tick_1s` input, 1 bit: one-cycle pulse once per second, synchronous to `clk_1khz`.
- `pill_in` input, 1 bit: asynchronous hopper pulse. One rising edge equals one pill.
- `start` input, 1 bit: QD button level. Acts on its rising edge.
- `clear` input, 1 bit: CLR button level, already active-high. Acts on its rising edge.
- `estop` input, 1 bit: emergency stop level.
- `conveyor_fault` input, 1 bit: conveyor-stopped level.
- `target_pills` input, 10 bits: pills per bottle, 0..999.
- `target_bottles` input, 7 bits: bottles per batch, 0..99.
- `state` output, 3 bits: 0 SETTING, 1 RUNNING, 2 SWITCHING, 3 DONE, 4 ERROR, 5 FATAL.
- `now_pills` output, 10 bits: pills in the current bottle.
- `now_bottles` output, 7 bits: completed bottles.
- `valve_open` output, 1 bit: hopper valve enable. High only in RUNNING.
- `conveyor_run` output, 1 bit: high only in SWITCHING.
- `alarm` output, 2 bits: 0 none, 1 DONE, 2 ERROR, 3 FATAL.

## Operation
- Reset (`rst_n`=0 at a clock edge) sets: state=SETTING; now_pills=0; now_bottles=0; both timers=0; valve_open=0; conveyor_run=0; alarm=0; all edge-detector history=0.
- Event priority, highest first: `estop`, then `clear` edge, then `start` edge, then pill edge, then timer expiry.
- **Any state:**
  - `estop`=1 goes to FATAL.
  - A `clear` edge with `estop`=0 goes to SETTING and zeroes both counters and both timers.
- **SETTING:**
  - A `start` edge latches `target_pills` and `target_bottles` into internal registers and goes to RUNNING.
  - The edge is ignored if either target is 0.
  - Target inputs are not sampled in any other state.
- **RUNNING:**
  - Entry loads the hopper timer with HOPPER_SECS.
  - Each pill edge increments now_pills and reloads the hopper timer.
  - When an increment makes now_pills equal to the latched pill target:
    - now_bottles increments.
    - If the new now_bottles equals the latched bottle target, go to DONE.
    - Otherwise go to SWITCHING.
  - now_pills holds the final count during the transition.
  - `tick_1s` decrements the hopper timer. Reaching 0 goes to ERROR.
- **SWITCHING:**
  - Entry clears now_pills and loads the switch timer with SWITCH_SECS.
  - `tick_1s` decrements the switch timer. Reaching 0 goes to RUNNING.
  - `conveyor_fault`=1 goes to ERROR.
  - Pill edges are discarded.
- **ERROR:**
  - Counters hold and pill edges are discarded.
  - A `start` edge resumes RUNNING if `conveyor_fault`=0.
  - If the ERROR came from SWITCHING, it resumes SWITCHING with the timer reloaded instead.
- **DONE:** holds until `clear` or `estop`. `start` is ignored.
- **FATAL:** holds while `estop`=1. After `estop` drops, only a `clear` edge exits, to SETTING.
- **Counter widths:** counters never wrap. The latched targets bound them to ≤999 and ≤99.
- **Timer ticks:** a `tick_1s` in the same cycle as a timer reload is absorbed by the reload, so a full period elapses.

## Timing
- All outputs are registered. `valve_open`, `conveyor_run` and `alarm` are decoded from the registered state and change in the same cycle as `state`.
- `start`, `clear` and `estop` are treated as synchronous inputs.
- Button edges are detected against a 1-cycle history register. `state` changes 1 cycle after the first cycle the button reads high.
- `pill_in` passes through a 2-flop synchronizer and then an edge register. now_pills updates 3 cycles after the pill edge (synchronous view).
- A timer expiry on a `tick_1s` cycle changes `state` at the next edge (1 cycle).
- A pill edge and a `tick_1s` that would expire the hopper timer in the same cycle: the pill wins (timer reloaded, no ERROR).
- Reset mid-operation takes effect at the next edge regardless of state.

## Configuration
- Macro: `FILL_PILL_DEBOUNCE_EN`.
- **Defined:** after synchronization, `pill_in` must be stable for 4 consecutive cycles before a level change is accepted. Pulses shorter than 4 ms are dropped. Count latency is 7 cycles.
- **Undefined:** no filter. Every synchronized rising edge counts. Latency is 3 cycles.

## Test plan
- **Normal batch.** Reset; targets 3/2; `start`; 3 pill pulses → SWITCHING with now_bottles=1. After 3 ticks → RUNNING with now_pills=0. Then 3 pills → DONE, now_bottles=2, alarm=1.
- **Starvation.** RUNNING with no pills for 5 ticks → ERROR, alarm=2, counters held. `start` → RUNNING, and the hopper timer restarts at 5.
- **Emergency stop.** `estop` in SWITCHING → FATAL, alarm=3. `clear` while `estop`=1 → stays FATAL. Drop `estop`, then `clear` → SETTING with counters 0.
- **Same-cycle pill and expiry.** A pill edge lands in the same cycle as the tick that expires the hopper timer → no ERROR, and now_pills increments.
- **Zero target and latching.** `target_pills`=0 plus `start` → remains SETTING. Then set 999/99, `start`, and change the target inputs in RUNNING → the latched targets are unaffected.
- **Debounce.** With `FILL_PILL_DEBOUNCE_EN`, a 2-cycle glitch on `pill_in` → no count, and a 10-cycle pulse → exactly one count. Without the macro, the same glitch → one count.
